// File: rtl/wb_writeback_if.sv
// Bundle of the retire handshake, data-memory read port and register-file write port
// that connects the writeback unit to the rest of the core.
interface wb_writeback_if;
    logic        wb_valid;
    logic        wb_ready;
    logic [1:0]  wb_sel;
    logic        reg_write_en;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic        RegWrite;
    logic [4:0]  write_rd;
    logic [31:0] write_data;
    logic        mem_err;

    // Handshake: an instruction is accepted at a rising edge where wb_valid && wb_ready;
    // mem_req stays high until the edge that samples the single-cycle mem_rvalid pulse.
    modport slave (
        input  wb_valid, wb_sel, reg_write_en, rd, funct3, alu_result, pc_plus4,
        input  mem_rdata, mem_rvalid,
        output wb_ready, mem_req, mem_addr, RegWrite, write_rd, write_data, mem_err
    );

    modport master (
        output wb_valid, wb_sel, reg_write_en, rd, funct3, alu_result, pc_plus4,
        output mem_rdata, mem_rvalid,
        input  wb_ready, mem_req, mem_addr, RegWrite, write_rd, write_data, mem_err
    );
endinterface

// File: rtl/wb_writeback_unit.sv
// Register-file write side: selects ALU / load / link result, runs the word read for
// loads with lane extraction, and stalls retirement while a load is outstanding.
module wb_writeback_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    wb_writeback_if.slave        bus,
    output logic [1:0]           o_state
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        WRITE    = 2'd2
    } state_t;

    state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic        r_wb_ready;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic        r_reg_write;
    logic [4:0]  r_write_rd;
    logic [31:0] r_write_data;
    logic        r_mem_err;
    logic [4:0]  r_rd_q;
    logic [2:0]  r_f3_q;
    logic [1:0]  r_off_q;
    logic        r_wen_q;

    logic        w_accept;
    logic        w_wen;
    logic        w_misaligned;
    logic        w_timeout;
    logic [31:0] w_load_data;

    function automatic logic [31:0] extract(input logic [31:0] d, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'd0, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'd0, h};
            default: res = d;
        endcase
        return res;
    endfunction

    assign w_accept    = bus.wb_valid && r_wb_ready;
    assign w_wen       = bus.reg_write_en && (bus.rd != 5'd0) && (bus.wb_sel != 2'd3);
    assign w_timeout   = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_load_data = extract(bus.mem_rdata, r_f3_q, r_off_q);

    // Reserved funct3 codes behave as lw, so they also need word alignment.
    always_comb begin
        w_misaligned = 1'b0;
        case (bus.funct3)
            3'b000, 3'b100: w_misaligned = 1'b0;
            3'b001, 3'b101: w_misaligned = bus.alu_result[0];
            default:        w_misaligned = (bus.alu_result[1:0] != 2'd0);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_wb_ready   <= 1'b1;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_reg_write  <= 1'b0;
            r_write_rd   <= '0;
            r_write_data <= '0;
            r_mem_err    <= 1'b0;
            r_rd_q       <= '0;
            r_f3_q       <= '0;
            r_off_q      <= '0;
            r_wen_q      <= 1'b0;
        end else begin
            r_reg_write <= 1'b0;
            r_mem_err   <= 1'b0;
            case (r_state)
                IDLE, WRITE: begin
                    if (w_accept) begin
                        r_rd_q  <= bus.rd;
                        r_f3_q  <= bus.funct3;
                        r_off_q <= bus.alu_result[1:0];
                        r_wen_q <= w_wen;
                        if (bus.wb_sel == 2'd1) begin
                            if (w_misaligned) begin
                                r_mem_err <= 1'b1;
                                r_state   <= IDLE;
                            end else begin
                                r_state    <= MEM_WAIT;
                                r_wb_ready <= 1'b0;
                                r_mem_req  <= 1'b1;
                                r_mem_addr <= {bus.alu_result[31:2], 2'b00};
                                r_cnt      <= '0;
                            end
                        end else begin
                            r_state     <= WRITE;
                            r_reg_write <= w_wen;
                            if (w_wen) begin
                                r_write_rd   <= bus.rd;
                                r_write_data <= (bus.wb_sel == 2'd2) ? bus.pc_plus4 : bus.alu_result;
                            end
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    // Response data takes priority over a timeout in the same cycle.
                    if (bus.mem_rvalid) begin
                        r_state     <= WRITE;
                        r_wb_ready  <= 1'b1;
                        r_mem_req   <= 1'b0;
                        r_reg_write <= r_wen_q;
                        if (r_wen_q) begin
                            r_write_rd   <= r_rd_q;
                            r_write_data <= w_load_data;
                        end
                    end else if (w_timeout) begin
                        r_state    <= IDLE;
                        r_wb_ready <= 1'b1;
                        r_mem_req  <= 1'b0;
                        r_mem_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_wb_ready <= 1'b1;
                    r_mem_req  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wb_ready   = r_wb_ready;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.RegWrite   = r_reg_write;
    assign bus.write_rd   = r_write_rd;
    assign bus.write_data = r_write_data;
    assign bus.mem_err    = r_mem_err;
    assign o_state        = r_state;

endmodule
